// File: rtl/ee357_seq_alu.sv
// ee357_seq_alu -- registered MIPS R-type ALU with iterative multiply/divide.
//
// Single-cycle funct codes (ADD/SUB/logic/SLT/shifts/HI-LO moves) complete on
// the edge that samples start. MULT/MULTU/DIV/DIVU take W cycles, one
// product/quotient bit per cycle, and write the architectural HI/LO registers.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, func       issue request and MIPS funct code (ignored while busy)
//   opa, opb          operands; shifts use opa[SHW-1:0] as amount, opb as data
//   res               registered result
//   uov, sov, zero,   registered flags (unsigned ovf/borrow, signed ovf,
//   cout              result zero, carry out)
//   dbz               last DIV/DIVU had a zero divisor
//   hi, lo            architectural HI/LO registers
//   busy, done        multi-cycle op in progress / one-cycle completion pulse
module ee357_seq_alu #(
   parameter int W   = 32,
   parameter int SHW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [5:0]   func,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   output logic [W-1:0] res,
   output logic         uov,
   output logic         sov,
   output logic         zero,
   output logic         cout,
   output logic         dbz,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         busy,
   output logic         done
);

   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                          F_OR  = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111,
                          F_SLT = 6'b101010, F_SLL = 6'b000000, F_SRL = 6'b000010,
                          F_SRA = 6'b000011, F_MFHI = 6'b010000, F_MTHI = 6'b010001,
                          F_MFLO = 6'b010010, F_MTLO = 6'b010011, F_MULT = 6'b011000,
                          F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [W-1:0]     op2_q, op2_d;
   logic [W-1:0]     opa_q, opa_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             dbz_pend_q, dbz_pend_d;
   logic [W-1:0]     res_q, res_d, hi_q, hi_d, lo_q, lo_d;
   logic             uov_q, uov_d, sov_q, sov_d, zero_q, zero_d, cout_q, cout_d;
   logic             dbz_q, dbz_d, done_q, done_d;

   // Magnitude of an operand; the most negative value maps to itself, which is
   // already the correct unsigned magnitude.
   function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
      return (sgn && x[W-1]) ? ('0 - x) : x;
   endfunction

   logic [SHW-1:0] sh_amt;
   logic [W:0]     add_sum, sub_sum;
   logic           add_sov, sub_sov;
   logic           sgn_op;
   logic [W:0]     mul_sum, div_sh, div_diff;
   logic [2*W-1:0] mul_next, div_next, prod_fix;
   logic [W-1:0]   quo_fix, rem_fix;
   logic           known;

   // Adder/subtractor shared by ADD, SUB and SLT, plus one multiply/divide step.
   // The divide step uses acc as {remainder, dividend/quotient} shifting left.
   always_comb begin
      sh_amt   = opa[SHW-1:0];
      add_sum  = {1'b0, opa} + {1'b0, opb};
      sub_sum  = {1'b0, opa} + {1'b0, ~opb} + {{W{1'b0}}, 1'b1};
      add_sov  = (opa[W-1] == opb[W-1]) && (add_sum[W-1] != opa[W-1]);
      sub_sov  = (opa[W-1] != opb[W-1]) && (sub_sum[W-1] != opa[W-1]);
      sgn_op   = ~func[0];
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, op2_q} : '0);
      mul_next = {mul_sum, acc_q[W-1:1]};
      div_sh   = acc_q[2*W-1:W-1];
      div_diff = div_sh - {1'b0, op2_q};
      div_next = div_diff[W] ? {div_sh[W-1:0], acc_q[W-2:0], 1'b0}
                             : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      prod_fix = neg_q ? ('0 - mul_next) : mul_next;
      quo_fix  = neg_q ? ('0 - div_next[W-1:0]) : div_next[W-1:0];
      rem_fix  = rneg_q ? ('0 - div_next[2*W-1:W]) : div_next[2*W-1:W];
   end

   // Next-state and output logic for the IDLE/RUN controller.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      op2_d      = op2_q;
      opa_d      = opa_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      dbz_pend_d = dbz_pend_q;
      res_d      = res_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      uov_d      = uov_q;
      sov_d      = sov_q;
      zero_d     = zero_q;
      cout_d     = cout_q;
      dbz_d      = dbz_q;
      done_d     = 1'b0;
      known      = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               uov_d  = 1'b0;
               sov_d  = 1'b0;
               cout_d = 1'b0;
               zero_d = 1'b0;
               done_d = 1'b1;
               case (func)
                  F_ADD: begin
                     res_d  = add_sum[W-1:0];
                     cout_d = add_sum[W];
                     uov_d  = add_sum[W];
                     sov_d  = add_sov;
                  end
                  F_SUB, F_SLT: begin
                     res_d  = (func == F_SLT) ? {{(W-1){1'b0}}, sub_sum[W-1] ^ sub_sov}
                                              : sub_sum[W-1:0];
                     cout_d = sub_sum[W];
                     uov_d  = ~sub_sum[W];
                     sov_d  = sub_sov;
                  end
                  F_AND:  res_d = opa & opb;
                  F_OR:   res_d = opa | opb;
                  F_XOR:  res_d = opa ^ opb;
                  F_NOR:  res_d = ~(opa | opb);
                  F_SLL:  res_d = opb << sh_amt;
                  F_SRL:  res_d = opb >> sh_amt;
                  F_SRA:  res_d = $unsigned($signed(opb) >>> sh_amt);
                  F_MFHI: res_d = hi_q;
                  F_MFLO: res_d = lo_q;
                  F_MTHI: begin
                     res_d = opa;
                     hi_d  = opa;
                  end
                  F_MTLO: begin
                     res_d = opa;
                     lo_d  = opa;
                  end
                  F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                     // Flags and res keep their old values until completion.
                     uov_d      = uov_q;
                     sov_d      = sov_q;
                     cout_d     = cout_q;
                     zero_d     = zero_q;
                     done_d     = 1'b0;
                     known      = 1'b0;
                     state_d    = S_RUN;
                     cnt_d      = SHW'(W-1);
                     opa_d      = opa;
                     is_div_d   = func[1];
                     neg_d      = sgn_op & (opa[W-1] ^ opb[W-1]);
                     rneg_d     = func[1] & sgn_op & opa[W-1];
                     dbz_pend_d = func[1] & (opb == '0);
                     if (func[1]) begin
                        op2_d = mag(opb, sgn_op);
                        acc_d = {{W{1'b0}}, mag(opa, sgn_op)};
                     end else begin
                        op2_d = mag(opa, sgn_op);
                        acc_d = {{W{1'b0}}, mag(opb, sgn_op)};
                     end
                  end
                  default: begin
                     res_d = '0;
                     known = 1'b0;
                  end
               endcase
               if (known) begin
                  zero_d = (res_d == '0);
               end
            end
         end
         S_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*W-1:W];
                  lo_d = prod_fix[W-1:0];
               end else if (dbz_pend_q) begin
                  hi_d = opa_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
               if (is_div_q) begin
                  dbz_d = dbz_pend_q;
               end
               res_d  = lo_d;
               uov_d  = 1'b0;
               sov_d  = 1'b0;
               cout_d = 1'b0;
               zero_d = ({hi_d, lo_d} == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         op2_q      <= '0;
         opa_q      <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         dbz_pend_q <= 1'b0;
         res_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         uov_q      <= 1'b0;
         sov_q      <= 1'b0;
         zero_q     <= 1'b0;
         cout_q     <= 1'b0;
         dbz_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         op2_q      <= op2_d;
         opa_q      <= opa_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         dbz_pend_q <= dbz_pend_d;
         res_q      <= res_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         uov_q      <= uov_d;
         sov_q      <= sov_d;
         zero_q     <= zero_d;
         cout_q     <= cout_d;
         dbz_q      <= dbz_d;
         done_q     <= done_d;
      end
   end

   assign res  = res_q;
   assign uov  = uov_q;
   assign sov  = sov_q;
   assign zero = zero_q;
   assign cout = cout_q;
   assign dbz  = dbz_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q == S_RUN);
   assign done = done_q;

endmodule

// File: tb/tb_ee357_seq_alu.sv
// Directed testbench for ee357_seq_alu: a W=32 instance for the main function
// and a W=8 instance for the narrow build.
module tb_ee357_seq_alu;

   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010,
                          F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011,
                          F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                          F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                          F_DIV = 6'b011010, F_DIVU = 6'b011011, F_BAD = 6'b111111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  func = '0;
   logic [31:0] opa = '0, opb = '0;
   logic [31:0] res, hi, lo;
   logic        uov, sov, zero, cout, dbz, busy, done;

   logic        s8_start = 1'b0;
   logic [5:0]  s8_func = '0;
   logic [7:0]  s8_opa = '0, s8_opb = '0;
   logic [7:0]  s8_res, s8_hi, s8_lo;
   logic        s8_uov, s8_sov, s8_zero, s8_cout, s8_dbz, s8_busy, s8_done;

   int total = 0;
   int bad = 0;
   int cyc;
   int seen;

   always #5 clk = ~clk;

   ee357_seq_alu #(.W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .func(func), .opa(opa), .opb(opb),
      .res(res), .uov(uov), .sov(sov), .zero(zero), .cout(cout), .dbz(dbz),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   ee357_seq_alu #(.W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8_start), .func(s8_func), .opa(s8_opa),
      .opb(s8_opb), .res(s8_res), .uov(s8_uov), .sov(s8_sov), .zero(s8_zero),
      .cout(s8_cout), .dbz(s8_dbz), .hi(s8_hi), .lo(s8_lo), .busy(s8_busy),
      .done(s8_done)
   );

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one request; returns at the falling edge after the sampling edge.
   task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      func  = f;
      opa   = a;
      opb   = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for done with a cycle budget; n = clock edges since the start edge.
   task automatic waitDone(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      checkOutput("rst_res", 64'(res), 64'h0);
      checkOutput("rst_flags", 64'({uov, sov, zero, cout, dbz}), 64'h0);
      checkOutput("rst_hilo", {hi, lo}, 64'h0);
      checkOutput("rst_busy_done", 64'({busy, done}), 64'h0);
      rst_n = 1'b1;

      applyStimulus(F_ADD, 32'hffffffff, 32'h00000001);
      checkOutput("add_res", 64'(res), 64'h0);
      checkOutput("add_flags", 64'({uov, sov, zero, cout}), 64'b1011);
      checkOutput("add_done", 64'({done, busy}), 64'b10);

      applyStimulus(F_BAD, 32'h12345678, 32'h1);
      checkOutput("bad_res", 64'(res), 64'h0);
      checkOutput("bad_flags", 64'({uov, sov, zero, cout, done}), 64'b00001);

      applyStimulus(F_SUB, 32'h80000000, 32'h00000001);
      checkOutput("sub_res", 64'(res), 64'h7fffffff);
      checkOutput("sub_flags", 64'({uov, sov, zero, cout}), 64'b0101);

      applyStimulus(F_SLT, 32'hffffffff, 32'hfffffffe);
      checkOutput("slt_res", 64'(res), 64'h0);
      checkOutput("slt_flags", 64'({uov, sov, zero, cout}), 64'b0011);

      applyStimulus(F_SLT, 32'h80000000, 32'h00000001);
      checkOutput("slt_ovf_res", 64'(res), 64'h1);

      applyStimulus(F_SRA, 32'h0000001f, 32'h80000000);
      checkOutput("sra_res", 64'(res), 64'hffffffff);

      applyStimulus(F_SLL, 32'h0000001c, 32'h0000000a);
      checkOutput("sll_res", 64'(res), 64'ha0000000);
      checkOutput("sll_flags", 64'({uov, sov, zero, cout}), 64'b0000);

      applyStimulus(F_MTHI, 32'hdeadbeef, 32'h0);
      checkOutput("mthi", {32'(res), hi}, 64'hdeadbeef_deadbeef);
      applyStimulus(F_MTLO, 32'h00000000, 32'h0);
      checkOutput("mtlo", 64'({lo, zero}), 64'h1);
      applyStimulus(F_MFHI, 32'h0, 32'h0);
      checkOutput("mfhi", 64'(res), 64'hdeadbeef);

      // MULT with a back-to-back MFHI in the done cycle
      applyStimulus(F_MULT, 32'hfffffffe, 32'h00000003);
      checkOutput("mult_busy", 64'(busy), 64'h1);
      waitDone(cyc);
      checkOutput("mult_latency", 64'(cyc), 64'd32);
      checkOutput("mult_hilo", {hi, lo}, 64'hffffffff_fffffffa);
      checkOutput("mult_res", 64'({res, uov, sov, zero, cout, busy}), {32'hfffffffa, 5'b0, 27'b0} >> 27);
      start = 1'b1;
      func  = F_MFHI;
      @(negedge clk);
      start = 1'b0;
      checkOutput("mfhi_b2b", 64'({res, done}), {31'b0, 32'hffffffff, 1'b1});

      applyStimulus(F_MULTU, 32'hfffffffe, 32'h00000003);
      waitDone(cyc);
      checkOutput("multu_hilo", {hi, lo}, 64'h00000002_fffffffa);

      applyStimulus(F_DIV, 32'hfffffff9, 32'h00000002);
      waitDone(cyc);
      checkOutput("div_hilo", {hi, lo}, 64'hffffffff_fffffffd);
      checkOutput("div_dbz", 64'(dbz), 64'h0);

      applyStimulus(F_DIVU, 32'h12345678, 32'h00000000);
      waitDone(cyc);
      checkOutput("divu0_hilo", {hi, lo}, 64'h12345678_ffffffff);
      checkOutput("divu0_dbz", 64'(dbz), 64'h1);

      applyStimulus(F_DIV, 32'h80000000, 32'hffffffff);
      waitDone(cyc);
      checkOutput("divovf_hilo", {hi, lo}, 64'h00000000_80000000);
      checkOutput("divovf_dbz_zero", 64'({dbz, zero}), 64'b00);

      // A second start while busy must be dropped
      applyStimulus(F_MULTU, 32'h00000005, 32'h00000007);
      repeat (2) @(negedge clk);
      start = 1'b1;
      func  = F_DIVU;
      opa   = 32'd100;
      opb   = 32'd3;
      @(negedge clk);
      start = 1'b0;
      checkOutput("ignore_busy", 64'(busy), 64'h1);
      waitDone(cyc);
      checkOutput("ignore_hilo", {hi, lo}, 64'h00000000_00000023);
      checkOutput("ignore_res", 64'(res), 64'h23);

      // Reset in the middle of a multiply
      applyStimulus(F_MULTU, 32'h00001234, 32'h00005678);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 64'({busy, done}), 64'b00);
      checkOutput("abort_hilo", {hi, lo}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      checkOutput("abort_no_done", 64'(seen), 64'h0);
      checkOutput("abort_hilo_hold", {hi, lo}, 64'h0);

      // Narrow build
      @(negedge clk);
      s8_start = 1'b1;
      s8_func  = F_MULTU;
      s8_opa   = 8'hff;
      s8_opb   = 8'hff;
      @(negedge clk);
      s8_start = 1'b0;
      cyc = 0;
      while (!s8_done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("w8_latency", 64'(cyc), 64'd8);
      checkOutput("w8_multu", 64'({s8_hi, s8_lo}), 64'hfe01);
      @(negedge clk);
      s8_start = 1'b1;
      s8_func  = F_SRL;
      s8_opa   = 8'h0b;
      s8_opb   = 8'h80;
      @(negedge clk);
      s8_start = 1'b0;
      checkOutput("w8_srl", 64'(s8_res), 64'h10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
